// File: rtl/riscv_pkg.sv
// Shared decode definitions for the 5-stage RISC-V core: ALUOp encodings,
// datapath width and the per-instruction control bundle carried down the pipe.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble must never write state or touch memory; alu_op falls back to add.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        alu_op:     ALUOP_MEM
    };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX boundary bundle. flush squashes EX on the next edge and wins over
// everything; hold freezes EX; stall_id asks upstream to freeze PC and IF/ID.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [1:0]      id_alu_op;
    logic            id_alu_src, id_mem_read, id_mem_write;
    logic            id_reg_write, id_mem_to_reg, id_branch;
    logic            flush, hold;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic            ex_uses_rs1, ex_uses_rs2;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [1:0]      ex_alu_op;
    logic            ex_alu_src, ex_mem_read, ex_mem_write;
    logic            ex_reg_write, ex_mem_to_reg, ex_branch;
    logic            stall_id;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_funct3, id_funct7, id_alu_op, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch, flush, hold,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_uses_rs1, ex_uses_rs2,
               ex_funct3, ex_funct7, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
               stall_id, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_funct3, id_funct7, id_alu_op, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch, flush, hold,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_uses_rs1, ex_uses_rs2,
               ex_funct3, ex_funct7, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
               stall_id, bubble_cnt, flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect #(
    parameter int RA_W = 5
) (
    input  logic            id_valid,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    output logic            lu
);

    logic rs1_hit, rs2_hit;

    assign rs1_hit = id_uses_rs1 & (ex_rd == id_rs1);
    assign rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);
    // x0 is hardwired, so a load targeting it never produces a dependency.
    assign lu = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// hold freeze and saturating bubble/flush event counters.
module id_ex_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    import riscv_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            uses_rs1;
        logic            uses_rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } dp_t;

    ctrl_t            id_ctrl, ex_ctrl;
    dp_t              id_dp, ex_dp;
    logic             ex_valid;
    logic             lu;
    logic             lu_bubble;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    assign id_ctrl = '{
        alu_src:    bus.id_alu_src,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        reg_write:  bus.id_reg_write,
        mem_to_reg: bus.id_mem_to_reg,
        branch:     bus.id_branch,
        alu_op:     bus.id_alu_op
    };

    assign id_dp = '{
        pc:       bus.id_pc,
        rs1_data: bus.id_rs1_data,
        rs2_data: bus.id_rs2_data,
        imm:      bus.id_imm,
        rs1:      bus.id_rs1,
        rs2:      bus.id_rs2,
        rd:       bus.id_rd,
        uses_rs1: bus.id_uses_rs1,
        uses_rs2: bus.id_uses_rs2,
        funct3:   bus.id_funct3,
        funct7:   bus.id_funct7
    };

    load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
        .id_valid    (bus.id_valid),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_dp.rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .lu          (lu)
    );

    // Priority: flush, then hold, then load-use, then plain capture.
    assign lu_bubble = ~bus.flush & ~bus.hold & lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dp    <= '0;
        end else if (bus.flush || lu_bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dp    <= id_dp;
        end else if (!bus.hold) begin
            ex_valid <= bus.id_valid;
            ex_ctrl  <= id_ctrl;
            ex_dp    <= id_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (bus.flush) begin
            if (~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
        end else if (lu_bubble) begin
            if (~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bus.stall_id      = (lu | bus.hold) & ~bus.flush;
    assign bus.bubble_cnt    = bubble_cnt;
    assign bus.flush_cnt     = flush_cnt;
    assign bus.ex_valid      = ex_valid;
    assign bus.ex_pc         = ex_dp.pc;
    assign bus.ex_rs1_data   = ex_dp.rs1_data;
    assign bus.ex_rs2_data   = ex_dp.rs2_data;
    assign bus.ex_imm        = ex_dp.imm;
    assign bus.ex_rs1        = ex_dp.rs1;
    assign bus.ex_rs2        = ex_dp.rs2;
    assign bus.ex_rd         = ex_dp.rd;
    assign bus.ex_uses_rs1   = ex_dp.uses_rs1;
    assign bus.ex_uses_rs2   = ex_dp.uses_rs2;
    assign bus.ex_funct3     = ex_dp.funct3;
    assign bus.ex_funct7     = ex_dp.funct7;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold table, random traffic
// against an instruction-level model, mid-run reset and counter saturation.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  // Narrow counters keep the saturation corner reachable in a short run.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            u1, u2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [1:0]      op;
    logic            src, mr, mw, rw, m2r, br;
  } instr_t;

  typedef struct {
    instr_t           id;
    logic             f, h;
    logic             exp_stall, exp_valid;
    logic [XLEN-1:0]  exp_pc;
    logic             exp_rw;
    logic [CNT_W-1:0] exp_bub, exp_fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  instr_t m;
  logic [CNT_W-1:0] m_bub, m_fl;
  logic m_stall, stall_s;
  vec_t tbl[16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t ins(logic v, logic [XLEN-1:0] pc, int rs1, int rs2, int rd,
                                 logic u1, logic u2, logic mr, logic rw);
    instr_t x = '0;
    x.valid = v; x.pc = pc; x.rs1 = rs1[RA_W-1:0]; x.rs2 = rs2[RA_W-1:0]; x.rd = rd[RA_W-1:0];
    x.u1 = u1; x.u2 = u2; x.mr = mr; x.rw = rw; x.m2r = mr; x.src = mr;
    x.op = mr ? riscv_pkg::ALUOP_MEM : riscv_pkg::ALUOP_R;
    x.a = pc ^ 32'h5a5a_0000; x.imm = {24'h0, pc[7:0]};
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x = '0;
    x.valid = ($urandom_range(0, 4) != 0);
    x.pc = $urandom; x.a = $urandom; x.b = $urandom; x.imm = $urandom;
    x.rs1 = RA_W'($urandom_range(0, 7)); x.rs2 = RA_W'($urandom_range(0, 7));
    x.rd = RA_W'($urandom_range(0, 7));
    x.u1 = 1'($urandom); x.u2 = 1'($urandom);
    x.f3 = 3'($urandom); x.f7 = 7'($urandom);
    if (x.valid) begin
      x.op = 2'($urandom_range(0, 2));
      x.mr = ($urandom_range(0, 2) == 0);
      x.src = 1'($urandom); x.mw = 1'($urandom); x.rw = 1'($urandom);
      x.m2r = 1'($urandom); x.br = 1'($urandom);
    end
    return x;
  endfunction

  function automatic vec_t mk(instr_t x, logic f, logic h, logic es, logic ev,
                              logic [XLEN-1:0] ep, logic er, int eb, int ef);
    vec_t v;
    v.id = x; v.f = f; v.h = h; v.exp_stall = es; v.exp_valid = ev;
    v.exp_pc = ep; v.exp_rw = er; v.exp_bub = eb[CNT_W-1:0]; v.exp_fl = ef[CNT_W-1:0];
    return v;
  endfunction

  function automatic instr_t killed(instr_t x);
    instr_t k = x;
    k.valid = 0; k.src = 0; k.mr = 0; k.mw = 0; k.rw = 0; k.m2r = 0; k.br = 0; k.op = 2'b00;
    return k;
  endfunction

  function automatic logic [CNT_W-1:0] sat(logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic instr_t dut_snap();
    instr_t s;
    s.valid = bus.ex_valid; s.pc = bus.ex_pc; s.a = bus.ex_rs1_data; s.b = bus.ex_rs2_data;
    s.imm = bus.ex_imm; s.rs1 = bus.ex_rs1; s.rs2 = bus.ex_rs2; s.rd = bus.ex_rd;
    s.u1 = bus.ex_uses_rs1; s.u2 = bus.ex_uses_rs2; s.f3 = bus.ex_funct3; s.f7 = bus.ex_funct7;
    s.op = bus.ex_alu_op; s.src = bus.ex_alu_src; s.mr = bus.ex_mem_read;
    s.mw = bus.ex_mem_write; s.rw = bus.ex_reg_write; s.m2r = bus.ex_mem_to_reg;
    s.br = bus.ex_branch;
    return s;
  endfunction

  task automatic drive(input instr_t x, input logic f, input logic h);
    bus.id_valid = x.valid; bus.id_pc = x.pc; bus.id_rs1_data = x.a; bus.id_rs2_data = x.b;
    bus.id_imm = x.imm; bus.id_rs1 = x.rs1; bus.id_rs2 = x.rs2; bus.id_rd = x.rd;
    bus.id_uses_rs1 = x.u1; bus.id_uses_rs2 = x.u2; bus.id_funct3 = x.f3; bus.id_funct7 = x.f7;
    bus.id_alu_op = x.op; bus.id_alu_src = x.src; bus.id_mem_read = x.mr;
    bus.id_mem_write = x.mw; bus.id_reg_write = x.rw; bus.id_mem_to_reg = x.m2r;
    bus.id_branch = x.br; bus.flush = f; bus.hold = h;
  endtask

  // Called at posedge+1: drive ID, sample stall mid-cycle, advance the model at the edge.
  task automatic step(input instr_t x, input logic f, input logic h);
    logic lu_m;
    drive(x, f, h);
    lu_m = x.valid && m.valid && m.mr && (m.rd != 0) &&
           ((x.u1 && m.rd == x.rs1) || (x.u2 && m.rd == x.rs2));
    m_stall = (lu_m || h) && !f;
    @(negedge clk);
    stall_s = bus.stall_id;
    @(posedge clk);
    if (f) begin
      m = killed(x); m_fl = sat(m_fl);
    end else if (h) begin
      m = m;
    end else if (lu_m) begin
      m = killed(x); m_bub = sat(m_bub);
    end else begin
      m = x;
    end
    #1;
  endtask

  task automatic model_reset();
    m = '0; m_bub = '0; m_fl = '0;
  endtask

  initial begin
    instr_t lw5, use5;
    model_reset();
    drive('0, 1'b0, 1'b0);

    // Reset with random ID traffic present.
    #2 rst_n = 1'b0;
    drive(rand_instr(), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ex", dut_snap(), '0);
    check("reset_stall", bus.stall_id, 0);
    check("reset_bubble_cnt", bus.bubble_cnt, 0);
    check("reset_flush_cnt", bus.flush_cnt, 0);
    drive('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0]  = mk(ins(1, 'h100, 2, 3, 1, 1, 1, 0, 1), 0, 0, 0, 1, 'h100, 1, 0, 0);
    tbl[1]  = mk(ins(1, 'h104, 1, 0, 5, 1, 0, 1, 1), 0, 0, 0, 1, 'h104, 1, 0, 0);
    tbl[2]  = mk(ins(1, 'h108, 5, 1, 6, 1, 1, 0, 1), 0, 0, 1, 0, 'h108, 0, 1, 0);
    tbl[3]  = mk(ins(1, 'h108, 5, 1, 6, 1, 1, 0, 1), 0, 0, 0, 1, 'h108, 1, 1, 0);
    tbl[4]  = mk(ins(1, 'h10c, 1, 0, 5, 1, 0, 1, 1), 0, 0, 0, 1, 'h10c, 1, 1, 0);
    tbl[5]  = mk(ins(1, 'h110, 7, 5, 6, 1, 0, 0, 1), 0, 0, 0, 1, 'h110, 1, 1, 0);
    tbl[6]  = mk(ins(1, 'h114, 1, 0, 0, 1, 0, 1, 1), 0, 0, 0, 1, 'h114, 1, 1, 0);
    tbl[7]  = mk(ins(1, 'h118, 0, 0, 7, 1, 1, 0, 1), 0, 0, 0, 1, 'h118, 1, 1, 0);
    tbl[8]  = mk(ins(1, 'h11c, 1, 0, 5, 1, 0, 1, 1), 0, 0, 0, 1, 'h11c, 1, 1, 0);
    tbl[9]  = mk(ins(1, 'h120, 5, 1, 6, 1, 1, 0, 1), 1, 0, 0, 0, 'h120, 0, 1, 1);
    tbl[10] = mk(ins(1, 'h124, 1, 0, 5, 1, 0, 1, 1), 0, 0, 0, 1, 'h124, 1, 1, 1);
    tbl[11] = mk(ins(1, 'h128, 9, 9, 6, 1, 1, 0, 1), 0, 1, 1, 1, 'h124, 1, 1, 1);
    tbl[12] = mk(ins(1, 'h12c, 10, 11, 7, 1, 1, 0, 1), 0, 1, 1, 1, 'h124, 1, 1, 1);
    tbl[13] = mk(ins(1, 'h130, 12, 13, 8, 1, 1, 0, 1), 0, 1, 1, 1, 'h124, 1, 1, 1);
    tbl[14] = mk(ins(1, 'h134, 9, 9, 6, 1, 1, 0, 1), 0, 0, 0, 1, 'h134, 1, 1, 1);
    tbl[15] = mk(ins(1, 'h138, 2, 3, 4, 1, 1, 0, 1), 1, 1, 0, 0, 'h138, 0, 1, 2);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].id, tbl[i].f, tbl[i].h);
      check($sformatf("vec%0d_stall", i), stall_s, tbl[i].exp_stall);
      check($sformatf("vec%0d_valid", i), bus.ex_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_pc", i), bus.ex_pc, tbl[i].exp_pc);
      check($sformatf("vec%0d_reg_write", i), bus.ex_reg_write, tbl[i].exp_rw);
      check($sformatf("vec%0d_bubble_cnt", i), bus.bubble_cnt, tbl[i].exp_bub);
      check($sformatf("vec%0d_flush_cnt", i), bus.flush_cnt, tbl[i].exp_fl);
    end

    // Random traffic against the instruction-level model.
    for (int i = 0; i < 3000; i++) begin
      step(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      check("rand_stall", stall_s, m_stall);
      check("rand_ex", dut_snap(), m);
      check("rand_bubble_cnt", bus.bubble_cnt, m_bub);
      check("rand_flush_cnt", bus.flush_cnt, m_fl);
    end

    // Reset in the middle of operation discards the EX instruction.
    step(ins(1, 'h200, 3, 4, 2, 0, 0, 0, 1), 1'b0, 1'b0);
    check("pre_reset_valid", bus.ex_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_ex", dut_snap(), '0);
    check("midreset_counters", {bus.bubble_cnt, bus.flush_cnt}, 0);
    check("midreset_stall", bus.stall_id, 0);
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Drive the bubble counter to saturation, then one more event.
    lw5  = ins(1, 'h300, 1, 0, 5, 1, 0, 1, 1);
    use5 = ins(1, 'h304, 5, 1, 6, 1, 1, 0, 1);
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      step(lw5, 1'b0, 1'b0);
      step(use5, 1'b0, 1'b0);
      check("sat_stall", stall_s, 1);
    end
    check("sat_reached", bus.bubble_cnt, {CNT_W{1'b1}});
    step(lw5, 1'b0, 1'b0);
    step(use5, 1'b0, 1'b0);
    check("sat_hold_stall", stall_s, 1);
    check("sat_no_wrap", bus.bubble_cnt, {CNT_W{1'b1}});
    check("sat_flush_cnt", bus.flush_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded operands and control from ID each cycle and presents them to EX, where `ex_alu_op`, `ex_funct3` and `ex_funct7` drive the ALU control decoder. It inserts bubbles on load-use hazards and squashes on branch flush. Two saturating event counters support performance debug.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RA_W`, 5, register-index width
- `CNT_W`, 16, event-counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: ID holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: ID datapath values
- `id_rs1`, `id_rs2`, `id_rd` in RA_W: register indices
- `id_uses_rs1`, `id_uses_rs2` in 1: instruction actually reads rs1 / rs2
- `id_funct3` in 3, `id_funct7` in 7, `id_alu_op` in 2: ALU decode fields
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch` in 1: control
- `flush` in 1: squash EX contents (branch taken / redirect)
- `hold` in 1: downstream stall; freeze EX contents
- `ex_*` out: registered copies of every `id_*` field above (same widths), plus `ex_valid` out 1
- `stall_id` out 1: freeze PC and IF/ID this cycle
- `bubble_cnt`, `flush_cnt` out CNT_W: saturating event counters

## Operation
- Load-use condition `lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2))`.
- `stall_id = (lu | hold) & ~flush`. Combinational from registered `ex_*` and current `id_*`.
- Per-edge update, first matching rule wins:
  1. `flush`: bubble into EX; `flush_cnt` increments.
  2. `hold`: all `ex_*` and `ex_valid` retain their values.
  3. `lu`: bubble into EX; `bubble_cnt` increments.
  4. Otherwise, capture: all `ex_*` take `id_*`, and `ex_valid = id_valid`.
- Bubble definition:
  - `ex_valid`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`, `ex_branch` = 0, and `ex_alu_op = 2'b00`.
  - Datapath and index fields (`ex_pc`, data, imm, rs1/rs2/rd, funct3/7) are loaded from ID, same as a capture.
- Capture with `id_valid = 0` passes the control bits through unchanged. Only `ex_valid` marks the instruction as invalid; decode guarantees zero controls for invalid ID.
- Counters saturate at all-ones and never wrap. Both counters share the same flush/hold/lu priority, so at most one increments per cycle.
- `ex_rd == 0` never causes a stall.

## Timing
- Latency: ID→EX is exactly 1 cycle. A value present at edge N is visible after edge N.
- Reset (async assert, sync deassert handled upstream): all `ex_*` = 0, `ex_valid` = 0, `ex_alu_op` = 00, counters = 0.
- `stall_id` reads 0 while in reset, because `ex_valid` = 0.
- Reset mid-operation: the in-flight EX instruction is discarded and nothing is retained.
- Simultaneous `flush` & `lu`: flush wins, and `stall_id` = 0 that cycle. The ID instruction is itself killed upstream by the same flush.
- Simultaneous `flush` & `hold`: flush wins. EX is squashed, and `stall_id` = 0.
- A load-use stall lasts exactly one cycle. After the bubble, `ex_valid` = 0, so `lu` drops and ID is captured on the next edge.

## Structure
- Shared package `riscv_pkg` holds:
  - ALUOp encodings `ALUOP_MEM = 2'b00`, `ALUOP_BR = 2'b01`, `ALUOP_R = 2'b10`
  - `XLEN`
  - packed struct `ctrl_t` {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, alu_op}
  - constant `CTRL_BUBBLE`
- Sub-module `load_use_detect` is pure combinational and produces `lu` from the EX and ID indices and flags. It is instantiated once.

## Test plan
- Reset with random `id_*` driven → all outputs 0 and `stall_id` = 0; after release, first capture of `id_pc = 0x100` → `ex_pc = 0x100` one edge later.
- `lw x5` in EX (`ex_mem_read` = 1, `ex_rd` = 5), ID `add x6,x5,x1` with `uses_rs1` → `stall_id` = 1 for one cycle, EX bubble (`ex_valid` = 0, `ex_reg_write` = 0), `bubble_cnt` = 1, then add captured.
- Same load with ID `addi x6,x7,5`, `uses_rs2` = 0 but `id_rs2 = 5` → no stall, direct capture. Load to `x0` with a matching index → no stall.
- `flush` and `lu` asserted together → `ex_valid` = 0, `stall_id` = 0, `flush_cnt` = 1, `bubble_cnt` unchanged.
- `hold` for 3 cycles with changing `id_*` → `ex_*` constant and `stall_id` = 1 throughout; capture resumes on the edge after `hold` drops.
- Force `bubble_cnt` to 0xFFFF via 65535 load-use events, then one more → stays 0xFFFF.
